spi_inst_loader: RTL and testbench

SPI program-load deserializer inside `opentitan_soc_top`, directly downstream of the `sel`/`spi_ss`/`spi_mosi` pins. While load mode is selected, it shifts in 32-bit words MSB-first, one bit per `clk_i`. It writes each completed word into instruction memory at consecutive word addresses through a req/gnt port. A one-entry holding register decouples SPI timing from memory back-pressure, and a sticky flag reports dropped words.

---
 rtl/spi_inst_loader.sv | 147 ++++++++++++++
 tb/tb_spi_inst_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_inst_loader.sv
// spi_inst_loader: SPI program-load deserializer.
// Shifts in 32-bit words MSB-first, one bit per clk_i, while sel_i is high.
// Each completed word is written to consecutive word addresses through a
// req/gnt memory port. A one-entry holding register absorbs memory
// back-pressure, and a sticky flag reports words dropped while it was full.
// Optional feature: define SPI_LOADER_CHECKSUM_EN to add checksum_o, the XOR
// of every word granted since the last load start.
module spi_inst_loader #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sel_i,
   input  logic                  spi_ss_i,
   input  logic                  spi_mosi_i,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [31:0]           word_count_o,
   output logic                  overflow_o,
   output logic                  busy_o
`ifdef SPI_LOADER_CHECKSUM_EN
   ,output logic [31:0]          checksum_o
`endif
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_e;

   state_e                 state_q;
   logic                   sel_q;
   logic [CW-1:0]          bit_cnt_q;
   logic [DATA_WIDTH-2:0]  shift_q;
   logic                   pend_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [31:0]            count_q;
   logic                   ovf_q;
`ifdef SPI_LOADER_CHECKSUM_EN
   logic [31:0]            csum_q;
`endif

   logic                   shift_en;
   logic                   word_done;
   logic                   grant;
   logic [DATA_WIDTH-1:0]  word_d;

   // Decode this edge's events: a bit shifted, a word completed, a grant taken.
   always_comb begin
      shift_en  = (state_q == S_RECV) && sel_i && !spi_ss_i;
      word_done = shift_en && (bit_cnt_q == LAST_BIT);
      word_d    = {shift_q, spi_mosi_i};
      grant     = pend_q && mem_gnt_i;
   end

   // Load FSM, shift register, holding register and status counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         sel_q     <= 1'b0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         pend_q    <= 1'b0;
         addr_q    <= BASE_ADDR;
         wdata_q   <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         sel_q <= sel_i;

         // Retire the held word; the pointer wraps naturally, the count saturates.
         if (grant) begin
            addr_q <= addr_q + ADDR_WIDTH'(4);
            if (count_q != 32'hFFFF_FFFF) begin
               count_q <= count_q + 32'd1;
            end
`ifdef SPI_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ 32'(wdata_q);
`endif
         end

         // A completed word loads only if the slot is free or freeing this edge.
         if (word_done) begin
            if (!pend_q || grant) begin
               wdata_q <= word_d;
               pend_q  <= 1'b1;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (grant) begin
            pend_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               bit_cnt_q <= '0;
               if (sel_i && !sel_q) begin
                  state_q <= S_RECV;
                  addr_q  <= BASE_ADDR;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
                  csum_q  <= '0;
`endif
               end
            end
            S_RECV: begin
               if (!sel_i) begin
                  // Partial word is abandoned; a held word still finishes.
                  state_q   <= S_IDLE;
                  bit_cnt_q <= '0;
               end else if (spi_ss_i) begin
                  bit_cnt_q <= '0;
               end else begin
                  shift_q   <= word_d[DATA_WIDTH-2:0];
                  bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req_o    = pend_q;
   assign mem_we_o     = pend_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign word_count_o = count_q;
   assign overflow_o   = ovf_q;
   assign busy_o       = (state_q == S_RECV) || pend_q;
`ifdef SPI_LOADER_CHECKSUM_EN
   assign checksum_o   = csum_q;
`endif

endmodule

// File: tb/tb_spi_inst_loader.sv
// Testbench for spi_inst_loader: directed SPI words, scoreboard of expected
// memory writes checked by an independent handshake monitor.
module tb_spi_inst_loader;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sel_i;
   logic        spi_ss_i;
   logic        spi_mosi_i;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] word_count_o;
   logic        overflow_o;
   logic        busy_o;
`ifdef SPI_LOADER_CHECKSUM_EN
   logic [31:0] checksum_o;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   spi_inst_loader #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .BASE_ADDR (BASE)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sel_i       (sel_i),
      .spi_ss_i    (spi_ss_i),
      .spi_mosi_i  (spi_mosi_i),
      .mem_req_o   (mem_req_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .word_count_o(word_count_o),
      .overflow_o  (overflow_o),
      .busy_o      (busy_o)
`ifdef SPI_LOADER_CHECKSUM_EN
      ,.checksum_o (checksum_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Inputs change right after a falling edge; this sits between two negedges.
   task automatic send_bit(input logic b);
      spi_ss_i   = 1'b0;
      spi_mosi_i = b;
      @(negedge clk_i);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic idle_cycles(input int n);
      spi_ss_i = 1'b1;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic start_load();
      sel_i    = 1'b1;
      spi_ss_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic restart_load();
      sel_i    = 1'b0;
      spi_ss_i = 1'b1;
      repeat (2) @(negedge clk_i);
      start_load();
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " req"},   32'(mem_req_o),  32'd0);
      chk({tag, " we"},    32'(mem_we_o),   32'd0);
      chk({tag, " ovf"},   32'(overflow_o), 32'd0);
      chk({tag, " busy"},  32'(busy_o),     32'd0);
      chk({tag, " addr"},  mem_addr_o,      BASE);
      chk({tag, " wdata"}, mem_wdata_o,     32'd0);
      chk({tag, " count"}, word_count_o,    32'd0);
   endtask

   // Monitor: a request with grant seen here completes on the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (rst_i === 1'b0 && mem_req_o === 1'b1 && mem_gnt_i === 1'b1) begin
            chk("write we", 32'(mem_we_o), 32'd1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected write: got addr %h data %h, expected none",
                        mem_addr_o, mem_wdata_o);
            end else begin
               e = exp_q.pop_front();
               chk("write addr", mem_addr_o, e.addr);
               chk("write data", mem_wdata_o, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst_i      = 1'b1;
      sel_i      = 1'b0;
      spi_ss_i   = 1'b1;
      spi_mosi_i = 1'b0;
      mem_gnt_i  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk_reset_vals("reset");
      rst_i = 1'b0;

      // Single word with grant tied high; request one cycle after bit 32.
      mem_gnt_i = 1'b1;
      start_load();
      push_exp(BASE, 32'hDEAD_BEEF);
      send_word(32'hDEAD_BEEF);
      #1;
      chk("t1 req latency", 32'(mem_req_o), 32'd1);
      chk("t1 busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      #1;
      chk("t1 req drop", 32'(mem_req_o), 32'd0);
      chk("t1 count", word_count_o, 32'd1);

      // Four back-to-back words, grant withheld for 40 cycles: word 2 dropped.
      mem_gnt_i = 1'b0;
      restart_load();
      push_exp(BASE,        32'h1111_AAAA);
      push_exp(BASE + 32'd4, 32'h3333_CCCC);
      push_exp(BASE + 32'd8, 32'h4444_DDDD);
      send_word(32'h1111_AAAA);
      fork
         begin
            send_word(32'h2222_BBBB);
            send_word(32'h3333_CCCC);
            send_word(32'h4444_DDDD);
         end
         begin
            repeat (40) @(negedge clk_i);
            mem_gnt_i = 1'b1;
         end
      join
      idle_cycles(4);
      #1;
      chk("t2 overflow", 32'(overflow_o), 32'd1);
      chk("t2 count", word_count_o, 32'd3);
      chk("t2 req idle", 32'(mem_req_o), 32'd0);

      // Framing resync: 17 bits then ss high, then a full word.
      restart_load();
      #1;
      chk("t3 ovf cleared", 32'(overflow_o), 32'd0);
      for (int i = 0; i < 17; i++) send_bit(1'b1);
      idle_cycles(1);
      push_exp(BASE, 32'h0000_0013);
      send_word(32'h0000_0013);
      idle_cycles(3);
      #1;
      chk("t3 count", word_count_o, 32'd1);

      // Drop sel while a word is pending, grant 3 cycles later.
      mem_gnt_i = 1'b0;
      restart_load();
      push_exp(BASE, 32'hA5A5_0F0F);
      send_word(32'hA5A5_0F0F);
      sel_i    = 1'b0;
      spi_ss_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("t4 still pending", 32'(mem_req_o), 32'd1);
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      #1;
      chk("t4 req done", 32'(mem_req_o), 32'd0);
      chk("t4 idle busy", 32'(busy_o), 32'd0);
      chk("t4 count", word_count_o, 32'd1);
      start_load();
      #1;
      chk("t4 addr restart", mem_addr_o, BASE);
      chk("t4 count restart", word_count_o, 32'd0);

      // Reset on bit 20 of a word while the previous word is pending.
      send_word(32'h0BAD_F00D);
      for (int i = 31; i >= 13; i--) send_bit(1'b1);
      rst_i      = 1'b1;
      spi_mosi_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk_reset_vals("midrst");
      start_load();
      mem_gnt_i = 1'b1;
      push_exp(BASE, 32'h600D_CAFE);
      send_word(32'h600D_CAFE);
      idle_cycles(3);
      #1;
      chk("t5 count", word_count_o, 32'd1);

`ifdef SPI_LOADER_CHECKSUM_EN
      // Checksum over two granted words.
      restart_load();
      #1;
      chk("t6 csum cleared", checksum_o, 32'd0);
      push_exp(BASE,         32'h1234_5678);
      push_exp(BASE + 32'd4, 32'h1111_1111);
      send_word(32'h1234_5678);
      send_word(32'h1111_1111);
      idle_cycles(3);
      #1;
      chk("t6 checksum", checksum_o, 32'h0325_4769);
`endif

      idle_cycles(4);
      chk("queue drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
